riscv_mmio_uart_tx: RTL
=======================

# riscv_mmio_uart_tx

Memory-mapped serial transmitter that responds to the core's data-memory bus (CSN/WEN/BE/ADDR/DI/DOUT) within a 16-byte address window. It sits beside the data SRAM. Stores to its data register push bytes into a TX FIFO, and an 8N1 serializer drives the `TXD` line. A registered `HIT` flag lets the top-level read-data mux select this block's `DOUT` over the SRAM's.

## Interface
- `BASE_ADDR`, default 32'h0000_3F00: window base; bits [3:0] must be 0.
- `FIFO_DEPTH`, default 8: TX FIFO entries; must be a power of 2, ≥2.
- `DIV_RESET`, default 16: reset value of the baud divisor (clocks per bit).
- `CLK` in 1: the single clock; all logic on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `CSN` in 1: chip select, active low.
- `WEN` in 1: 0 = write, 1 = read.
- `BE` in 4: byte enables, active high, writes only.
- `ADDR` in 32: byte address.
- `DI` in 32: write data from the core.
- `DOUT` out 32: registered read data.
- `HIT` out 1: registered; 1 when the previous cycle's access was in-window.
- `TXD` out 1: serial output, idle high.
- `IRQ` out 1: registered; high when the FIFO is empty and the serializer is idle.

## Operation
- Access condition: `CSN`=0 and `ADDR[31:4]`==`BASE_ADDR[31:4]`. Otherwise the block ignores the bus.
- Register offsets use `ADDR[3:2]`; `ADDR[1:0]` are ignored.
- 0x0 TXDATA:
  - Write with `BE[0]`=1 pushes `DI[7:0]`.
  - Write with `BE[0]`=0 is ignored.
  - Reads return 0.
- 0x4 STATUS, read:
  - [0] full, [1] empty, [2] busy (serializer not IDLE), [3] overflow (sticky).
  - [11:8] FIFO count, saturating at 15.
  - Other bits 0.
  - Write with `BE[0]`=1 and `DI[3]`=1 clears overflow (W1C); other bits read-only.
- 0x8 DIV:
  - [15:0] clocks per bit; read/write per byte lane (`BE[1:0]`).
  - A stored value of 0 behaves as 1.
- 0xC TXCNT:
  - 32-bit count of completed frames; wraps at 2^32.
  - Any write with any `BE` bit set clears it to 0.
- Push when full: byte dropped, overflow set, count unchanged. Fullness is evaluated on the pre-edge count, so a same-cycle pop does not make room.
- FIFO: circular, log2(FIFO_DEPTH)-bit pointers wrapping to 0; the count has one extra bit.
- Serializer FSM:
  - IDLE: `TXD`=1. If FIFO non-empty, pop the head into the shift register, latch DIV into the bit timer, go to START.
  - START: `TXD`=0 for DIV cycles, then go to DATA.
  - DATA: 8 bits LSB first, DIV cycles each.
  - STOP: `TXD`=1 for DIV cycles. At the end, TXCNT+1 and return to IDLE. The next pop occurs in IDLE, so there is one idle cycle between frames.
- DIV writes during a frame take effect at the next frame start.
- Simultaneous TXCNT clear and frame completion: the clear wins (result 0).
- Simultaneous overflow set and W1C clear: the set wins.

## Timing
- Reset values:
  - `DOUT`=0, `HIT`=0, `TXD`=1, `IRQ`=1.
  - FIFO empty (pointers 0), overflow 0, DIV=`DIV_RESET`, TXCNT=0, FSM IDLE.
- Reset mid-frame: `TXD`=1 from the edge that samples `RST`=1. The frame is aborted, the FIFO flushed, and TXCNT is not incremented.
- Read latency:
  - The access is sampled at edge N; `DOUT`/`HIT` are valid after edge N, held until the next sampled access.
  - On non-hit cycles `HIT`=0 and `DOUT`=0.
- Write: register or FIFO update at edge N.
- TXDATA write at edge N with FIFO empty and FSM idle:
  - Pop at edge N+1, `TXD` falls after N+1.
  - Data bit 0 after N+1+DIV; stop bit after N+1+9·DIV.
  - IDLE after N+1+10·DIV; TXCNT updates at that edge.
- STATUS read reflects state before edge N.
- `IRQ` updates one cycle after empty∧idle changes.

## Test plan
- Reset check: hold `RST` 2 cycles → `TXD`=1, `IRQ`=1; STATUS read returns 0x0000_0002; DIV read returns 16.
- Single byte: write DIV=4, then TXDATA=0xA5 at edge N → `TXD` sequence 0,1,0,1,0,0,1,0,1,1, each 4 cycles, starting after N+1; TXCNT reads 1; `IRQ` rises.
- Overflow: with DIV=100, write 10 bytes back-to-back (0x00..0x09) → first pops immediately, bytes 0x01..0x08 fill the FIFO, 0x09 is dropped. STATUS shows full=1, overflow=1, count=8; frames 0x00..0x08 are transmitted, TXCNT=9. W1C clears overflow.
- Window decode: write 0xFF to `BASE_ADDR`+0x10 and read `BASE_ADDR`−4 → no push, `HIT`=0, `DOUT`=0. Write TXDATA with `BE`=4'b1110 → no push.
- Reset mid-frame: assert `RST` during DATA bit 3 → `TXD`=1 next cycle, STATUS=0x2, TXCNT=0, no further frames.
- TXCNT clear at completion: write TXCNT in the same cycle the STOP bit ends → TXCNT reads 0.

Source files
------------

// File: rtl/riscv_mmio_uart_tx_if.sv
// Data-memory bus bundle shared by the core (master) and MMIO peripherals (slave).
// Signal names follow the core's bus naming: CSN/WEN active-low, BE active-high.
interface riscv_mmio_uart_tx_if;
  logic        CSN;
  logic        WEN;
  logic [3:0]  BE;
  logic [31:0] ADDR;
  logic [31:0] DI;
  logic [31:0] DOUT;
  logic        HIT;

  modport master (output CSN, WEN, BE, ADDR, DI, input DOUT, HIT);
  modport slave  (input CSN, WEN, BE, ADDR, DI, output DOUT, HIT);
endinterface

// File: rtl/riscv_mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter living in a 16-byte window of the data bus.
// Registers: 0x0 TXDATA (push), 0x4 STATUS, 0x8 DIV (clocks per bit), 0xC TXCNT.
// Stores to TXDATA feed a circular FIFO; a four-state serializer drains it.
module riscv_mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_3F00,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic                     CLK,
  input  logic                     RST,
  riscv_mmio_uart_tx_if.slave      bus,
  output logic                     TXD,
  output logic                     IRQ
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Bus decode
  logic       acc, wr, rd;
  logic [1:0] off;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_req, push, pop, full, empty;

  // Registers
  logic        ovf_q, ovf_d;
  logic [15:0] div_q, div_d, div_eff;
  logic [31:0] txcnt_q, txcnt_d;
  logic [31:0] dout_q, dout_d, rdata;
  logic        hit_q, hit_d;
  logic        irq_q, irq_d;
  logic [31:0] cnt_ext;
  logic [3:0]  cnt_sat;

  // Serializer
  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] reload_q, reload_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        txd_q, txd_d;
  logic        frame_done;

  // Bits of the bus this block never looks at.
  logic unused_bits;
  assign unused_bits = ^{bus.ADDR[1:0], bus.DI[31:16]};

  assign acc   = !bus.CSN && (bus.ADDR[31:4] == BASE_ADDR[31:4]);
  assign wr    = acc && !bus.WEN;
  assign rd    = acc && bus.WEN;
  assign off   = bus.ADDR[3:2];

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;

  // Serializer next-state: each phase lasts reload_q+1 cycles; the divisor is
  // latched only when a byte is popped so mid-frame DIV writes wait a frame.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    timer_d    = timer_q;
    reload_d   = reload_q;
    bit_idx_d  = bit_idx_q;
    pop        = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          reload_d  = div_eff - 16'd1;
          timer_d   = div_eff - 16'd1;
          bit_idx_d = 3'd0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (timer_q == 16'd0) begin
          timer_d = reload_q;
          state_d = S_DATA;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_DATA: begin
        if (timer_q == 16'd0) begin
          timer_d = reload_q;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_STOP: begin
        if (timer_q == 16'd0) begin
          frame_done = 1'b1;
          state_d    = S_IDLE;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // FIFO pointers, register writes and read-data mux. Fullness uses the
  // pre-edge count, so a same-cycle pop never rescues an overflowing push.
  always_comb begin
    push_req = wr && (off == 2'd0) && bus.BE[0];
    push     = push_req && !full;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Set beats W1C clear when both land on the same edge.
    ovf_d = ovf_q;
    if (wr && (off == 2'd1) && bus.BE[0] && bus.DI[3]) ovf_d = 1'b0;
    if (push_req && full)                              ovf_d = 1'b1;

    div_d = div_q;
    if (wr && (off == 2'd2)) begin
      if (bus.BE[0]) div_d[7:0]  = bus.DI[7:0];
      if (bus.BE[1]) div_d[15:8] = bus.DI[15:8];
    end

    // Clear beats frame completion.
    txcnt_d = frame_done ? txcnt_q + 32'd1 : txcnt_q;
    if (wr && (off == 2'd3) && (|bus.BE)) txcnt_d = 32'd0;

    cnt_ext = 32'(count_q);
    cnt_sat = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];
    case (off)
      2'd1:    rdata = {20'd0, cnt_sat, 4'd0, ovf_q, (state_q != S_IDLE), empty, full};
      2'd2:    rdata = {16'd0, div_q};
      2'd3:    rdata = txcnt_q;
      default: rdata = 32'd0;
    endcase
    dout_d = rd ? rdata : 32'd0;
    hit_d  = acc;
    irq_d  = empty && (state_q == S_IDLE);
  end

  // FIFO storage: write-only port, no reset needed (pointers define validity).
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= bus.DI[7:0];
  end

  // State registers with synchronous reset; reset also aborts any frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      div_q     <= DIV_RESET;
      txcnt_q   <= 32'd0;
      dout_q    <= 32'd0;
      hit_q     <= 1'b0;
      irq_q     <= 1'b1;
      state_q   <= S_IDLE;
      shift_q   <= 8'd0;
      timer_q   <= 16'd0;
      reload_q  <= 16'd0;
      bit_idx_q <= 3'd0;
      txd_q     <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      div_q     <= div_d;
      txcnt_q   <= txcnt_d;
      dout_q    <= dout_d;
      hit_q     <= hit_d;
      irq_q     <= irq_d;
      state_q   <= state_d;
      shift_q   <= shift_d;
      timer_q   <= timer_d;
      reload_q  <= reload_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
    end
  end

  assign bus.DOUT = dout_q;
  assign bus.HIT  = hit_q;
  assign TXD      = txd_q;
  assign IRQ      = irq_q;

endmodule
